// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
package uart_pkg;

  // 50 MHz system clock at roughly 921.6 kbaud
  localparam int DEFAULT_CLKS_PER_BIT = 54;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_state_e;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop synchronizer for a single asynchronous bit
module sync_ff #(
  parameter int   DEPTH       = 2,
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stages;

  // Shift the raw input through DEPTH flops; the last one is the only one used
  always_ff @(posedge clock) begin
    if (!reset) begin
      stages <= {DEPTH{RESET_VALUE}};
    end else begin
      stages <= {stages[DEPTH-2:0], d};
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with mid-bit sampling and framing check
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] uart_data,
  output logic       uart_data_rdy,
  output logic       framing_error
);

  // A synchronizer shallower than two flops is not metastability safe
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT + 1);

  // Half a bit to reach mid-start, then full bits between samples.
  // The counter reloads at zero, so a full period is CLKS_PER_BIT-1 downto 0.
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_sync;
  logic             rx_prev;
  uart_state_e      state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;

  sync_ff #(
    .DEPTH       (STAGES),
    .RESET_VALUE (1'b1)
  ) u_rx_sync (
    .clock (clock),
    .reset (reset),
    .d     (uart_rx),
    .q     (rx_sync)
  );

  // Delayed copy of the synchronized line, tracked in every state so a start
  // edge arriving in the back half of a stop bit is still seen from IDLE
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_prev <= 1'b1;
    end else begin
      rx_prev <= rx_sync;
    end
  end

  // Frame sequencer: edge detect, mid-start check, 8 data samples, stop check
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      uart_data     <= 8'h00;
      uart_data_rdy <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      uart_data_rdy <= 1'b0;
      framing_error <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state   <= ST_START;
            bit_cnt <= HALF_BIT;
          end
        end

        ST_START: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else if (!rx_sync) begin
            state   <= ST_DATA;
            bit_idx <= 3'd0;
            bit_cnt <= FULL_BIT;
          end else begin
            // Line went back high before mid-start: a glitch, not a frame
            state <= ST_IDLE;
          end
        end

        ST_DATA: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else begin
            shift_reg <= {rx_sync, shift_reg[7:1]};
            bit_cnt   <= FULL_BIT;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        ST_STOP: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else if (rx_sync) begin
            uart_data     <= shift_reg;
            uart_data_rdy <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            framing_error <= 1'b1;
            state         <= ST_WAIT_IDLE;
          end
        end

        ST_WAIT_IDLE: begin
          // Ignore everything until the line returns to idle
          if (rx_sync) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - randomized self-checking bench for uart_receiver
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int CPB  = 54;
  localparam int SYNC = 2;
  localparam int LAT_MIN = (CPB * 19) / 2;
  localparam int LAT_MAX = LAT_MIN + SYNC + 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] uart_data;
  logic       uart_data_rdy;
  logic       framing_error;

  uart_receiver #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .uart_rx       (uart_rx),
    .uart_data     (uart_data),
    .uart_data_rdy (uart_data_rdy),
    .framing_error (framing_error)
  );

  always #10 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Reference model: bytes the line carried with a good stop bit, in order
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         rdy_cyc[$];
  int         rdy_cnt = 0;
  int         fe_cnt = 0;
  int         overlap = 0;
  int         long_pulse = 0;
  logic       prev_rdy = 1'b0;
  logic       prev_fe = 1'b0;
  int         fall_cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observe outputs half a cycle away from the active edge
  always @(negedge clock) begin
    if (uart_data_rdy) begin
      got_q.push_back(uart_data);
      rdy_cyc.push_back(cyc);
      rdy_cnt++;
    end
    if (framing_error) fe_cnt++;
    if (uart_data_rdy && framing_error) overlap++;
    if ((uart_data_rdy && prev_rdy) || (framing_error && prev_fe)) long_pulse++;
    prev_rdy = uart_data_rdy;
    prev_fe  = framing_error;
  end

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_v);
    if (stop_v) exp_q.push_back(b);
  endtask

  task automatic idle_bits(input int n);
    uart_rx = 1'b1;
    repeat (n * CPB) @(negedge clock);
  endtask

  task automatic drain_check(input string tag);
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check_eq({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    uart_rx = 1'b1;
    reset = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int base_rdy;
    int base_fe;
    int lat;
    logic [31:0] word;

    // Reset state
    uart_rx = 1'b1;
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check_eq("rst_data", uart_data, 8'h00);
    check_eq("rst_rdy", uart_data_rdy, 1'b0);
    check_eq("rst_fe", framing_error, 1'b0);
    check_eq("rst_state", 32'(dut.state), 32'(ST_IDLE));
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Single byte, with latency from pin edge to ready
    base_fe = fe_cnt;
    send_frame(8'hA5, 1'b1);
    idle_bits(2);
    check_eq("a5_pulses", got_q.size(), 1);
    if (rdy_cyc.size() > 0) lat = rdy_cyc[rdy_cyc.size() - 1] - fall_cyc;
    else lat = 0;
    check_eq("a5_latency_ok", (lat >= LAT_MIN && lat <= LAT_MAX), 1'b1);
    check_eq("a5_fe", fe_cnt - base_fe, 0);
    drain_check("a5");

    // Back-to-back extremes with no idle gap
    rdy_cyc.delete();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle_bits(2);
    if (rdy_cyc.size() == 2) lat = rdy_cyc[1] - rdy_cyc[0];
    else lat = 0;
    check_eq("b2b_spacing_ok", (lat >= 10 * CPB - 2 && lat <= 10 * CPB + 2), 1'b1);
    drain_check("b2b");

    // Short low glitch must not start a frame
    base_rdy = rdy_cnt;
    base_fe = fe_cnt;
    uart_rx = 1'b0;
    repeat (10) @(negedge clock);
    uart_rx = 1'b1;
    repeat (100) @(negedge clock);
    check_eq("glitch_rdy", rdy_cnt - base_rdy, 0);
    check_eq("glitch_fe", fe_cnt - base_fe, 0);
    check_eq("glitch_state", 32'(dut.state), 32'(ST_IDLE));

    // Bad stop bit, then a good frame
    do_reset();
    base_fe = fe_cnt;
    send_frame(8'h3C, 1'b0);
    idle_bits(2);
    check_eq("fe_pulses", fe_cnt - base_fe, 1);
    check_eq("fe_data_kept", uart_data, 8'h00);
    check_eq("fe_no_rdy", got_q.size(), 0);
    send_frame(8'h7E, 1'b1);
    idle_bits(2);
    drain_check("fe_recover");

    // Reset in the middle of bit 4, then a clean frame
    do_reset();
    base_rdy = rdy_cnt;
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 4; i++) drive_bit(logic'((8'hC3 >> i) & 8'h01));
    uart_rx = 1'b0;
    repeat (CPB / 2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("midrst_data", uart_data, 8'h00);
    uart_rx = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    idle_bits(12);
    check_eq("midrst_no_pulse", rdy_cnt - base_rdy, 0);
    send_frame(8'h5A, 1'b1);
    idle_bits(2);
    check_eq("midrst_data_5a", uart_data, 8'h5A);
    drain_check("midrst");

    // Little-endian word assembly
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    idle_bits(1);
    send_frame(8'h03, 1'b1);
    send_frame(8'h04, 1'b1);
    idle_bits(2);
    word = 32'h0;
    if (got_q.size() == 4) word = {got_q[3], got_q[2], got_q[1], got_q[0]};
    check_eq("word", word, 32'h04030201);
    drain_check("word");

    // Random bytes, random good/bad stop, random idle gaps (including none)
    base_fe = fe_cnt;
    lat = 0;
    for (int n = 0; n < 16; n++) begin
      logic [7:0] b;
      logic       good;
      b = 8'($urandom);
      good = ($urandom_range(0, 5) != 0);
      send_frame(b, good);
      if (!good) begin
        lat++;
        idle_bits(1);
      end else begin
        idle_bits($urandom_range(0, 2));
      end
    end
    idle_bits(2);
    check_eq("rand_fe", fe_cnt - base_fe, lat);
    drain_check("rand");

    check_eq("rdy_fe_overlap", overlap, 0);
    check_eq("pulse_width", long_pulse, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
